// File: rtl/conv_wbuf_pkg.sv
// Shared definitions for the N-bank weight buffer: the per-bank ownership states.
package conv_wbuf_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

endpackage

// File: rtl/conv_wbank_state.sv
// Ownership state of one weight bank: loader fills it, compute drains it,
// and an optional hold keeps the weights resident for another pass.
module conv_wbank_state
  import conv_wbuf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       claim_wr,
  input  logic       fill_done,
  input  logic       claim_rd,
  input  logic       drain_done,
  input  logic       hold,
  output logic [1:0] state
);

  bank_state_e r_state;
  bank_state_e w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      EMPTY:    if (claim_wr)   w_next = FILLING;
      FILLING:  if (fill_done)  w_next = FULL;
      FULL:     if (claim_rd)   w_next = DRAINING;
      DRAINING: if (drain_done) w_next = hold ? FULL : EMPTY;
      default:                  w_next = EMPTY;
    endcase
  end

  assign state = r_state;

endmodule

// File: rtl/conv_weights_nbank_controller.sv
// Rotates NUM_BANKS weight RAM banks between the DDR loader and the conv read port,
// with per-bank handshakes, optional weight reuse and a latency-aligned read return.
module conv_weights_nbank_controller
  import conv_wbuf_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int WORD_W    = 512,
  parameter int ADR_W     = 16,
  parameter int RD_LAT    = 1,
  parameter int BIDX_W    = $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wt_start,
  output logic                        wt_ready,
  input  logic                        wt_done,
  input  logic                        wt_en,
  input  logic [ADR_W-1:0]            wt_adr,
  input  logic [WORD_W-1:0]           wt_data,
  input  logic                        rd_start,
  output logic                        rd_ready,
  input  logic                        rd_done,
  input  logic                        rd_hold,
  input  logic                        rd_en,
  input  logic [ADR_W-1:0]            rd_adr,
  output logic [WORD_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic [NUM_BANKS-1:0]        bank_en,
  output logic [NUM_BANKS-1:0]        bank_we,
  output logic [NUM_BANKS*ADR_W-1:0]  bank_adr,
  output logic [NUM_BANKS*WORD_W-1:0] bank_din,
  input  logic [NUM_BANKS*WORD_W-1:0] bank_dout,
  output logic [BIDX_W:0]             full_count,
  output logic                        proto_err
);

  logic [1:0]           w_state [NUM_BANKS];
  logic [NUM_BANKS-1:0] w_claim_wr, w_fill_done, w_claim_rd, w_drain_done;

  logic [BIDX_W-1:0] r_wr_ptr, r_rd_ptr, r_wr_bank, r_rd_bank;
  logic              r_filling, r_draining;

  logic w_wt_start_ok, w_wt_done_ok, w_rd_start_ok, w_rd_done_ok, w_rd_en_ok;
  logic w_err;
  logic [BIDX_W:0] w_full_cnt;

  logic [BIDX_W-1:0] r_rsel_p [RD_LAT];
  logic [RD_LAT-1:0] r_vld_p;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [BIDX_W:0]   r_full_count;
  logic              r_proto_err;

  function automatic logic [BIDX_W-1:0] ptr_inc(input logic [BIDX_W-1:0] p);
    if (p == BIDX_W'(NUM_BANKS - 1)) return '0;
    return p + BIDX_W'(1);
  endfunction

  // A second FILLING/DRAINING bank is never allowed, even if the next bank is free
  assign wt_ready = (w_state[r_wr_ptr] == EMPTY) && !r_filling;
  assign rd_ready = (w_state[r_rd_ptr] == FULL)  && !r_draining;

  assign w_wt_start_ok = wt_start && wt_ready;
  assign w_wt_done_ok  = wt_done  && r_filling;
  assign w_rd_start_ok = rd_start && rd_ready;
  assign w_rd_done_ok  = rd_done  && r_draining;
  assign w_rd_en_ok    = rd_en    && r_draining;

  assign w_err = (wt_start && !wt_ready) || (rd_start && !rd_ready) ||
                 (wt_en    && !r_filling) || (rd_en   && !r_draining) ||
                 (wt_done  && !r_filling) || (rd_done && !r_draining);

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign w_claim_wr[g]   = w_wt_start_ok && (r_wr_ptr  == BIDX_W'(g));
    assign w_fill_done[g]  = w_wt_done_ok  && (r_wr_bank == BIDX_W'(g));
    assign w_claim_rd[g]   = w_rd_start_ok && (r_rd_ptr  == BIDX_W'(g));
    assign w_drain_done[g] = w_rd_done_ok  && (r_rd_bank == BIDX_W'(g));

    conv_wbank_state u_state (
      .clk        (clk),
      .reset      (reset),
      .claim_wr   (w_claim_wr[g]),
      .fill_done  (w_fill_done[g]),
      .claim_rd   (w_claim_rd[g]),
      .drain_done (w_drain_done[g]),
      .hold       (rd_hold),
      .state      (w_state[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_bank  <= '0;
      r_rd_bank  <= '0;
      r_filling  <= 1'b0;
      r_draining <= 1'b0;
    end else begin
      if (w_wt_start_ok) begin
        r_wr_bank <= r_wr_ptr;
        r_wr_ptr  <= ptr_inc(r_wr_ptr);
        r_filling <= 1'b1;
      end else if (w_wt_done_ok) begin
        r_filling <= 1'b0;
      end
      if (w_rd_start_ok) begin
        r_rd_bank  <= r_rd_ptr;
        r_draining <= 1'b1;
      end else if (w_rd_done_ok) begin
        r_draining <= 1'b0;
        if (!rd_hold) r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  always_comb begin
    bank_en  = '0;
    bank_we  = '0;
    bank_adr = '0;
    bank_din = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (r_filling && (r_wr_bank == BIDX_W'(i))) begin
        bank_en[i]                   = wt_en;
        bank_we[i]                   = wt_en;
        bank_adr[i*ADR_W +: ADR_W]   = wt_adr;
        bank_din[i*WORD_W +: WORD_W] = wt_data;
      end else if (r_draining && (r_rd_bank == BIDX_W'(i))) begin
        bank_en[i]                 = rd_en;
        bank_adr[i*ADR_W +: ADR_W] = rd_adr;
      end
    end
  end

  always_comb begin
    w_full_cnt = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (w_state[i] == FULL) w_full_cnt = w_full_cnt + (BIDX_W+1)'(1);
  end

  // Read return: bank select rides with valid so reads issued before rd_done still land
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) r_rsel_p[i] <= '0;
      r_vld_p      <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_full_count <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_vld_p[0]  <= w_rd_en_ok;
      r_rsel_p[0] <= r_rd_bank;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_p[i]  <= r_vld_p[i-1];
        r_rsel_p[i] <= r_rsel_p[i-1];
      end
      r_rd_valid <= r_vld_p[RD_LAT-1];
      if (r_vld_p[RD_LAT-1])
        r_rd_data <= bank_dout[r_rsel_p[RD_LAT-1]*WORD_W +: WORD_W];
      r_full_count <= w_full_cnt;
      r_proto_err  <= w_err;
    end
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign full_count = r_full_count;
  assign proto_err  = r_proto_err;

endmodule
